// File: rtl/fpu_div_issuer.sv
// FPU-side initiator for the divider wrapper's start/finish handshake.
// Registers operands, pulses startOp, tracks finishOp and returns the quotient or an abort.
module fpu_div_issuer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             startOp,
    input  logic             finishOp,
    input  logic [WIDTH-1:0] div_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t        state;
    logic [CW-1:0] waitCount;
    logic [CW-1:0] nextCount;
    logic          lastWait;

    // Saturating step: one wait cycle consumed; never wraps past TIMEOUT-1.
    assign lastWait  = (waitCount == LAST_COUNT);
    assign nextCount = lastWait ? LAST_COUNT : waitCount + 1'b1;

    // NOTE: req_ready is the only combinational output; a wrapper still busy from an
    // aborted op keeps finishOp low and therefore blocks the next request.
    assign req_ready = (state == IDLE) && finishOp;

    // NOTE: all state and outputs below use non-blocking assignments so every flop
    // samples pre-edge values; a blocking '=' here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            waitCount   <= '0;
            div_a       <= '0;
            div_b       <= '0;
            startOp     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            startOp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && finishOp) begin
                        div_a     <= req_a;
                        div_b     <= req_b;
                        waitCount <= '0;
                        startOp   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!finishOp) begin
                        waitCount <= nextCount;
                        state     <= WAIT_DONE;
                    end else if (lastWait) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESPOND;
                    end else begin
                        waitCount <= nextCount;
                    end
                end
                WAIT_DONE: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (finishOp) begin
                        rsp_result  <= div_result;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESPOND;
                    end else if (lastWait) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESPOND;
                    end else begin
                        waitCount <= nextCount;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
